// File: rtl/iob2axi_burst_ctrl.sv
// Splits one transfer request into AXI4 bursts (max 2^AXI_LEN_W beats, no 4 KB crossing)
// and sequences the read/write engines. Define IOB2AXI_ABORT_ON_ERR_EN to stop on the first engine error.
module iob2axi_burst_ctrl #(
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned AXI_LEN_W  = 8,
  parameter int unsigned XFER_LEN_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  direction,
  input  logic [AXI_ADDR_W-1:0] addr,
  input  logic [XFER_LEN_W-1:0] length,
  output logic                  ready,
  output logic                  error,
  output logic                  eng_run_rd,
  output logic                  eng_run_wr,
  output logic [AXI_ADDR_W-1:0] eng_addr,
  output logic [AXI_LEN_W-1:0]  eng_length,
  input  logic                  eng_ready_rd,
  input  logic                  eng_ready_wr,
  input  logic                  eng_error_rd,
  input  logic                  eng_error_wr
);

  localparam int unsigned BYTES = AXI_DATA_W / 8;
  localparam int unsigned LOG2B = $clog2(BYTES);
  localparam int unsigned CW    = (XFER_LEN_W > AXI_LEN_W + 13) ? XFER_LEN_W : AXI_LEN_W + 13;
  localparam logic [AXI_ADDR_W-1:0] ADDR_MASK = ~AXI_ADDR_W'(BYTES - 1);
  localparam logic [AXI_LEN_W:0]    BEATS_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE,
    S_WAIT_FIRST,
    S_WAIT
  } state_t;

  state_t                  state_q, state_d;
  logic [AXI_ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [XFER_LEN_W-1:0]   remaining_q, remaining_d;
  logic                    dir_q, dir_d;
  logic [AXI_LEN_W:0]      beats_q, beats_d;
  logic [AXI_LEN_W-1:0]    len_q, len_d;
  logic                    err_q, err_d;

  logic [CW-1:0]           to4k, rem_ext, max_ext;
  logic [AXI_LEN_W:0]      beats_calc;
  logic [AXI_ADDR_W-1:0]   step_bytes;
  logic                    sel_ready, sel_err;

  // Selecting the winning operand by full-width compares keeps every bit significant
  // and avoids truncating before the minimum is known.
  always_comb begin
    to4k    = (CW'(4096) - CW'(cur_addr_q[11:0])) >> LOG2B;
    rem_ext = CW'(remaining_q);
    max_ext = CW'(1) << AXI_LEN_W;
    if (rem_ext <= to4k && rem_ext <= max_ext) begin
      beats_calc = rem_ext[AXI_LEN_W:0];
    end else if (to4k <= max_ext) begin
      beats_calc = to4k[AXI_LEN_W:0];
    end else begin
      beats_calc = max_ext[AXI_LEN_W:0];
    end
  end

  assign step_bytes = AXI_ADDR_W'(beats_q) << LOG2B;
  assign sel_ready  = dir_q ? eng_ready_wr : eng_ready_rd;
  assign sel_err    = dir_q ? eng_error_wr : eng_error_rd;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    beats_d     = beats_q;
    len_d       = len_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (run && length != '0) begin
          cur_addr_d  = addr & ADDR_MASK;
          remaining_d = length;
          dir_d       = direction;
          err_d       = 1'b0;
          state_d     = S_CALC;
        end
      end
      S_CALC: begin
        beats_d = beats_calc;
        len_d   = AXI_LEN_W'(beats_calc - BEATS_ONE);
        state_d = S_ISSUE;
      end
      S_ISSUE:      state_d = S_WAIT_FIRST;
      // The engine still reports ready on the cycle right after the pulse.
      S_WAIT_FIRST: state_d = S_WAIT;
      S_WAIT: begin
        if (sel_ready) begin
          err_d       = err_q | sel_err;
          cur_addr_d  = cur_addr_q + step_bytes;
          remaining_d = remaining_q - XFER_LEN_W'(beats_q);
          state_d     = (remaining_d == '0) ? S_IDLE : S_CALC;
`ifdef IOB2AXI_ABORT_ON_ERR_EN
          if (sel_err) state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      dir_q       <= 1'b0;
      beats_q     <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      beats_q     <= beats_d;
      len_q       <= len_d;
      err_q       <= err_d;
    end
  end

  assign ready      = (state_q == S_IDLE);
  assign error      = err_q;
  assign eng_run_rd = (state_q == S_ISSUE) && !dir_q;
  assign eng_run_wr = (state_q == S_ISSUE) && dir_q;
  assign eng_addr   = cur_addr_q;
  assign eng_length = len_q;

endmodule
